sms4_round_engine: RTL and testbench

SMS4_ROUND_ENGINE -- requirements
Module: sms4_round_engine

---
 rtl/sms4_round_engine.sv | 112 +++++++++++
 tb/tb_sms4_round_engine.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sms4_round_engine.sv
// SMS4 block cipher round engine: one round per clock, 32 rounds per block.
// Round keys come from an external key store addressed by rk_idx.
module sms4_round_engine (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    input  logic         dec,
    output logic [4:0]   rk_idx,
    input  logic [31:0]  rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Byte i of the S-box lives at bits [2047-8*i -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    state_t      state, state_nxt;
    logic [31:0] x0, x1, x2, x3;
    logic        mode;
    logic [4:0]  cnt;
    logic [31:0] round_in, round_t, x_new;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] base;
        base = 11'd2047 - {a, 3'b000};
        return SBOX_TABLE[base -: 8];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    endfunction

    function automatic logic [31:0] l_lin(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    assign round_in = x1 ^ x2 ^ x3 ^ rk;
    assign round_t  = l_lin(tau(round_in));
    assign x_new    = x0 ^ round_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 5'd0;
        dout      = 128'h0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                // 31-cnt is the bitwise inverse of a 5-bit counter.
                rk_idx = mode ? ~cnt : cnt;
                if (cnt == 5'd31) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                dout      = {x3, x2, x1, x0};
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0   <= 32'h0;
            x1   <= 32'h0;
            x2   <= 32'h0;
            x3   <= 32'h0;
            mode <= 1'b0;
            cnt  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {x0, x1, x2, x3} <= din;
                        mode             <= dec;
                        cnt              <= 5'd0;
                    end
                end
                RUN: begin
                    {x0, x1, x2, x3} <= {x1, x2, x3, x_new};
                    if (cnt != 5'd31) cnt <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sms4_round_engine.sv
// Directed and randomized checks of sms4_round_engine against the published
// SMS4 test vector and a small software model with its own key schedule.
module tb_sms4_round_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         dec = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] din = 128'h0;
    logic         in_ready, out_valid;
    logic [127:0] dout;
    logic [4:0]   rk_idx;
    logic [31:0]  rk;
    logic [31:0]  rk_mem [32];

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] KEY_STD = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT_STD  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT_STD  = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [2047:0] SBOX_TB = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    sms4_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .dec       (dec),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    assign rk = rk_mem[rk_idx];

    function automatic logic [7:0] sbox8(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_TB[idx -: 8];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau32(input logic [31:0] a);
        return {sbox8(a[31:24]), sbox8(a[23:16]), sbox8(a[15:8]), sbox8(a[7:0])};
    endfunction

    function automatic logic [31:0] l_enc(input logic [31:0] b);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    task automatic key_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++)
                ck[31 - 8 * j -: 8] = 8'(((4 * i + j) * 7) % 256);
            k[i + 4] = k[i] ^ l_key(tau32(k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck));
            rk_mem[i] = k[i + 4];
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] blk, input logic m);
        logic [31:0] x [4];
        logic [31:0] xn;
        x[0] = blk[127:96]; x[1] = blk[95:64]; x[2] = blk[63:32]; x[3] = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            xn = x[0] ^ l_enc(tau32(x[1] ^ x[2] ^ x[3] ^ rk_mem[m ? 31 - i : i]));
            x[0] = x[1]; x[1] = x[2]; x[2] = x[3]; x[3] = xn;
        end
        return {x[3], x[2], x[1], x[0]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns at the negedge where out_valid is seen.
    task automatic run_block(input logic [127:0] blk, input logic m,
                             output logic [127:0] res, output int lat, output int rk_err);
        din = blk; dec = m; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0; rk_err = 0;
        while (!out_valid && lat < 100) begin
            if (lat < 32 && rk_idx !== 5'(m ? 31 - lat : lat)) rk_err++;
            @(negedge clk);
            lat++;
        end
        res = dout;
    endtask

    task automatic pop_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ovalid_low"}, 128'(out_valid), 128'd0);
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] res, first_d, expv;
        logic [127:0] blk [3];
        logic [127:0] exp_b2b [3];
        int lat, rk_err, bad, cyc, acc_n, out_n, last_acc, gap_err;
        int lost, dup, unstable, c, got, seen;
        logic pre_acc, pre_out, m;

        key_expand(KEY_STD);

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        check("rst_dout", dout, 128'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);

        // Encrypt standard vector
        run_block(PT_STD, 1'b0, res, lat, rk_err);
        check("enc_latency", 128'(lat), 128'd32);
        check("enc_rk_seq_errors", 128'(rk_err), 128'd0);
        check("enc_dout", res, CT_STD);
        pop_result("enc");

        // Decrypt standard vector, reverse key order
        run_block(CT_STD, 1'b1, res, lat, rk_err);
        check("dec_latency", 128'(lat), 128'd32);
        check("dec_rk_seq_errors", 128'(rk_err), 128'd0);
        check("dec_dout", res, PT_STD);
        pop_result("dec");

        // Backpressure in DONE with ignored in_valid pulses
        run_block(PT_STD, 1'b0, res, lat, rk_err);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || dout !== CT_STD || in_ready !== 1'b0) bad++;
            in_valid = i[0];
            din = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_hold_errors", 128'(bad), 128'd0);
        check("bp_dout", dout, CT_STD);
        pop_result("bp");

        // Reset in the middle of a run
        din = PT_STD; dec = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_rk_idx_15", 128'(rk_idx), 128'd15);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 128'(in_ready), 128'd0);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
        check("mid_rst_dout", dout, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        check("mid_rst_no_output", 128'(bad), 128'd0);
        run_block(PT_STD, 1'b0, res, lat, rk_err);
        check("after_rst_latency", 128'(lat), 128'd32);
        check("after_rst_dout", res, CT_STD);
        pop_result("after_rst");

        // Back-to-back blocks with in_valid and out_ready held high
        blk[0] = 128'h00112233445566778899aabbccddeeff;
        blk[1] = CT_STD;
        blk[2] = 128'hffffffff00000000a5a5a5a55a5a5a5a;
        for (int i = 0; i < 3; i++) exp_b2b[i] = model(blk[i], 1'b0);
        out_ready = 1'b1; dec = 1'b0; din = blk[0]; in_valid = 1'b1;
        acc_n = 0; out_n = 0; last_acc = 0; gap_err = 0; cyc = 0;
        while (out_n < 3 && cyc < 400) begin
            pre_acc = in_ready && in_valid;
            pre_out = out_valid;
            res = dout;
            @(negedge clk);
            cyc++;
            if (pre_out) begin
                check($sformatf("b2b_dout_%0d", out_n), res, exp_b2b[out_n]);
                out_n++;
            end
            if (pre_acc) begin
                if (acc_n > 0 && cyc - last_acc != 34) gap_err++;
                last_acc = cyc;
                acc_n++;
                if (acc_n < 3) din = blk[acc_n];
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("b2b_outputs", 128'(out_n), 128'd3);
        check("b2b_accepts", 128'(acc_n), 128'd3);
        check("b2b_period_errors", 128'(gap_err), 128'd0);
        @(negedge clk);

        // Random keys, blocks, modes and handshakes
        lost = 0; dup = 0; unstable = 0;
        for (int b = 0; b < 200; b++) begin
            key_expand({$urandom, $urandom, $urandom, $urandom});
            blk[0] = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            expv = model(blk[0], m);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            din = blk[0]; dec = m; in_valid = 1'b1;
            @(negedge clk);
            got = 0; seen = 0; c = 0; first_d = 128'h0;
            while (got == 0 && c < 200) begin
                in_valid = 1'($urandom_range(0, 1));
                din = {$urandom, $urandom, $urandom, $urandom};
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid) begin
                    if (seen == 0) first_d = dout;
                    else if (dout !== first_d) unstable++;
                    seen = 1;
                    if (out_ready) got = 1;
                end
                @(negedge clk);
                c++;
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            if (got == 0) lost++;
            if (out_valid !== 1'b0) dup++;
            check($sformatf("rand_dout_%0d", b), first_d, expv);
        end
        check("rand_lost", 128'(lost), 128'd0);
        check("rand_dup", 128'(dup), 128'd0);
        check("rand_unstable", 128'(unstable), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
